// File: rtl/load_extract_unit.sv
// load_extract_unit: read-side partner of the store byte-insert logic.
// Takes a load request (byte address, size, signedness), issues a word-aligned
// read over a req/gnt/rvalid port, then picks the addressed byte/halfword lane,
// sign- or zero-extends it and hands the 32-bit result back over valid/ready.
// Misaligned or reserved-size requests answer with an error and never touch
// memory.
// Optional build macro: LOAD_TIMEOUT_EN adds a watchdog on the WAIT state that
// returns an error result (32'hDEAD_BEEF) after TIMEOUT_CYCLES without rvalid.

module load_extract_unit #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [1:0]        ld_size,
  input  logic              ld_unsigned,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              res_valid,
  output logic [31:0]       res_data,
  output logic              res_err,
  input  logic              res_ready
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_RESP
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_e            state_q, state_d;
  logic [1:0]        off_q, off_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       res_data_q, res_data_d;
  logic              res_err_q, res_err_d;

  logic              req_bad;
  logic [7:0]        byte_lane;
  logic [15:0]       half_lane;
  logic [31:0]       extracted;

`ifdef LOAD_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]  cnt_q, cnt_d;
`endif

  // Handshake outputs are pure decodes of the state, so reset drops them at once.
  assign ld_ready  = (state_q == ST_IDLE);
  assign mem_req   = (state_q == ST_REQ);
  assign res_valid = (state_q == ST_RESP);
  assign mem_addr  = mem_addr_q;
  assign res_data  = res_data_q;
  assign res_err   = res_err_q;

  // Flag requests that cannot be served by one aligned word read.
  always_comb begin
    req_bad = 1'b0;
    if (ld_size == 2'b11) begin
      req_bad = 1'b1;
    end else if ((ld_size == SZ_HALF) && ld_addr[0]) begin
      req_bad = 1'b1;
    end else if ((ld_size == SZ_WORD) && (ld_addr[1:0] != 2'b00)) begin
      req_bad = 1'b1;
    end
  end

  // Pick the little-endian lane from the returned word and extend it.
  always_comb begin
    byte_lane = mem_rdata[8*off_q +: 8];
    half_lane = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      SZ_BYTE: extracted = {{24{~uns_q & byte_lane[7]}}, byte_lane};
      SZ_HALF: extracted = {{16{~uns_q & half_lane[15]}}, half_lane};
      default: extracted = mem_rdata;
    endcase
  end

  // Next-state and datapath register updates for the load sequence.
  always_comb begin
    state_d    = state_q;
    off_d      = off_q;
    size_d     = size_q;
    uns_d      = uns_q;
    mem_addr_d = mem_addr_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
`ifdef LOAD_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (ld_valid) begin
          off_d      = ld_addr[1:0];
          size_d     = ld_size;
          uns_d      = ld_unsigned;
          mem_addr_d = {ld_addr[ADDR_W-1:2], 2'b00};
          if (req_bad) begin
            res_err_d  = 1'b1;
            res_data_d = 32'h0;
            state_d    = ST_RESP;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (mem_gnt) begin
          state_d = ST_WAIT;
`ifdef LOAD_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ST_WAIT: begin
        if (mem_rvalid) begin
          res_data_d = extracted;
          res_err_d  = 1'b0;
          state_d    = ST_RESP;
        end
`ifdef LOAD_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          res_data_d = 32'hDEAD_BEEF;
          res_err_d  = 1'b1;
          state_d    = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      ST_RESP: begin
        if (res_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= ST_IDLE;
      off_q      <= 2'b00;
      size_q     <= 2'b00;
      uns_q      <= 1'b0;
      mem_addr_q <= '0;
      res_data_q <= 32'h0;
      res_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      off_q      <= off_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      mem_addr_q <= mem_addr_d;
      res_data_q <= res_data_d;
      res_err_q  <= res_err_d;
    end
  end

`ifdef LOAD_TIMEOUT_EN
  // Watchdog counter of WAIT cycles spent without read data.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_load_extract_unit.sv
// Self-checking bench for load_extract_unit: directed vector table, random
// loads against a behavioural model, and reset-during-transaction sequences.

module tb_load_extract_unit;

  logic        clk;
  logic        nrst;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_addr;
  logic [1:0]  ld_size;
  logic        ld_unsigned;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        res_valid;
  logic [31:0] res_data;
  logic        res_err;
  logic        res_ready;

  int checks;
  int failures;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] rdata;
    int          gnt_dly;
    int          rv_dly;
    int          rdy_dly;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  load_extract_unit #(
    .ADDR_W(32),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk        (clk),
    .nrst       (nrst),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_addr    (ld_addr),
    .ld_size    (ld_size),
    .ld_unsigned(ld_unsigned),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_err    (res_err),
    .res_ready  (res_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Behavioural reference: arithmetic on byte offset and lane width.
  function automatic void refModel(input logic [31:0] addr, input logic [1:0] size,
                                   input logic uns, input logic [31:0] rdata,
                                   output logic [31:0] data, output logic err);
    int    off;
    int    nbytes;
    longint v;
    off = int'(addr % 4);
    if (size == 2'd3 || (size == 2'd1 && (off % 2) != 0) || (size == 2'd2 && off != 0)) begin
      err  = 1'b1;
      data = 32'h0;
      return;
    end
    err    = 1'b0;
    nbytes = 1 << size;
    v      = longint'(rdata) >> (8 * off);
    if (nbytes < 4) begin
      v = v % (longint'(1) << (8 * nbytes));
      if (!uns && v >= (longint'(1) << (8 * nbytes - 1)))
        v = v - (longint'(1) << (8 * nbytes));
    end
    data = v[31:0];
  endfunction

  function automatic vec_t mkVec(input logic [31:0] addr, input logic [1:0] size, input logic uns,
                                 input logic [31:0] rdata, input int g, input int r, input int k,
                                 input logic [31:0] ed, input logic ee, input int el);
    vec_t v;
    v.addr = addr; v.size = size; v.uns = uns; v.rdata = rdata;
    v.gnt_dly = g; v.rv_dly = r; v.rdy_dly = k;
    v.exp_data = ed; v.exp_err = ee; v.exp_lat = el;
    return v;
  endfunction

  // Runs one load end-to-end, playing memory and consumer, and checks the result.
  task automatic applyStimulus(input string name, input vec_t v);
    logic [31:0] exp_addr;
    logic [31:0] got_data;
    logic        got_err;
    int          cyc, gnt_cnt, rv_cnt, rdy_cnt, lat, guard;
    bit          granted, rv_sent, seen_valid, done, req_seen, addr_ok, stable_ok;
    exp_addr = {v.addr[31:2], 2'b00};
    got_data = 32'h0; got_err = 1'b0;
    gnt_cnt = 0; rv_cnt = 0; rdy_cnt = 0; lat = -1; guard = 0;
    granted = 0; rv_sent = 0; seen_valid = 0; done = 0;
    req_seen = 0; addr_ok = 1; stable_ok = 1;
    while (!ld_ready && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    if (!ld_ready) begin
      checks++; failures++;
      $display("[TB] FAIL %s ready_wait: ld_ready=%0b expected 1", name, ld_ready);
      return;
    end
    ld_valid = 1'b1; ld_addr = v.addr; ld_size = v.size; ld_unsigned = v.uns;
    @(posedge clk); #1;
    ld_valid = 1'b0; ld_addr = $urandom; ld_size = 2'($urandom); ld_unsigned = 1'($urandom);
    cyc = 1;
    while (!done && cyc < 200) begin
      mem_gnt = 1'b0; mem_rvalid = 1'b0; res_ready = 1'b0; mem_rdata = $urandom;
      if (mem_req) begin
        req_seen = 1;
        if (mem_addr !== exp_addr) addr_ok = 0;
        if (gnt_cnt == v.gnt_dly) begin
          mem_gnt = 1'b1; granted = 1;
        end else begin
          gnt_cnt++;
          mem_rvalid = 1'b1; mem_rdata = ~v.rdata;
        end
      end else if (granted && !rv_sent) begin
        if (rv_cnt == v.rv_dly) begin
          mem_rvalid = 1'b1; mem_rdata = v.rdata; rv_sent = 1;
        end else begin
          rv_cnt++;
        end
      end
      if (res_valid) begin
        if (!seen_valid) begin
          seen_valid = 1; lat = cyc; got_data = res_data; got_err = res_err;
        end else if (res_data !== got_data || res_err !== got_err) begin
          stable_ok = 0;
        end
        if (ld_ready) stable_ok = 0;
        if (rdy_cnt == v.rdy_dly) begin
          res_ready = 1'b1; done = 1;
        end else begin
          rdy_cnt++;
        end
      end
      @(posedge clk); #1; cyc++;
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0; res_ready = 1'b0;
    if (!done) begin
      checks++; failures++;
      $display("[TB] FAIL %s no_response: cycles=%0d expected result within 200", name, cyc);
      return;
    end
    checkOutput({name, " data"}, got_data, v.exp_data);
    checkOutput({name, " err"}, {31'h0, got_err}, {31'h0, v.exp_err});
    checkOutput({name, " latency"}, lat, v.exp_lat);
    checkOutput({name, " mem_req_seen"}, {31'h0, req_seen}, {31'h0, ~v.exp_err});
    checkOutput({name, " mem_addr_stable"}, {31'h0, addr_ok}, 32'h1);
    checkOutput({name, " result_stable"}, {31'h0, stable_ok}, 32'h1);
    checkOutput({name, " valid_drop"}, {30'h0, res_valid, ld_ready}, 32'h1);
  endtask

  task automatic checkResetValues(input string name);
    checkOutput({name, " ld_ready"}, {31'h0, ld_ready}, 32'h1);
    checkOutput({name, " mem_req"}, {31'h0, mem_req}, 32'h0);
    checkOutput({name, " mem_addr"}, mem_addr, 32'h0);
    checkOutput({name, " res_valid"}, {31'h0, res_valid}, 32'h0);
    checkOutput({name, " res_data"}, res_data, 32'h0);
    checkOutput({name, " res_err"}, {31'h0, res_err}, 32'h0);
  endtask

  vec_t vecs[14];

  initial begin
    vec_t rv;
    logic [31:0] md;
    logic        me;
    checks = 0; failures = 0;
    nrst = 1'b0; ld_valid = 1'b0; ld_addr = 32'h0; ld_size = 2'b00; ld_unsigned = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0; res_ready = 1'b0;

    vecs[0]  = mkVec(32'h8123_4561, 2'd0, 1'b0, 32'hAAAA_80AA, 0, 0, 0, 32'hFFFF_FF80, 1'b0, 3);
    vecs[1]  = mkVec(32'h8123_4560, 2'd0, 1'b1, 32'h4433_2211, 0, 0, 0, 32'h0000_0011, 1'b0, 3);
    vecs[2]  = mkVec(32'h8123_4561, 2'd0, 1'b1, 32'h4433_2211, 0, 0, 0, 32'h0000_0022, 1'b0, 3);
    vecs[3]  = mkVec(32'h8123_4562, 2'd0, 1'b1, 32'h4433_2211, 0, 0, 0, 32'h0000_0033, 1'b0, 3);
    vecs[4]  = mkVec(32'h8123_4563, 2'd0, 1'b1, 32'h4433_2211, 0, 0, 0, 32'h0000_0044, 1'b0, 3);
    vecs[5]  = mkVec(32'h8123_4562, 2'd1, 1'b0, 32'h8001_AAAA, 0, 0, 0, 32'hFFFF_8001, 1'b0, 3);
    vecs[6]  = mkVec(32'h8123_4562, 2'd1, 1'b1, 32'h8001_AAAA, 0, 0, 0, 32'h0000_8001, 1'b0, 3);
    vecs[7]  = mkVec(32'h8123_4563, 2'd1, 1'b0, 32'h1234_5678, 0, 0, 0, 32'h0000_0000, 1'b1, 1);
    vecs[8]  = mkVec(32'h8123_4561, 2'd2, 1'b0, 32'h1234_5678, 0, 0, 2, 32'h0000_0000, 1'b1, 1);
    vecs[9]  = mkVec(32'h8123_4560, 2'd3, 1'b1, 32'h1234_5678, 0, 0, 0, 32'h0000_0000, 1'b1, 1);
    vecs[10] = mkVec(32'h8123_4564, 2'd2, 1'b1, 32'hCAFE_F00D, 4, 0, 3, 32'hCAFE_F00D, 1'b0, 7);
    vecs[11] = mkVec(32'h0000_1008, 2'd0, 1'b0, 32'h0000_007F, 0, 1, 0, 32'h0000_007F, 1'b0, 4);
    vecs[12] = mkVec(32'h0000_2000, 2'd2, 1'b0, 32'h1234_5678, 0, 15, 0, 32'h1234_5678, 1'b0, 18);
`ifdef LOAD_TIMEOUT_EN
    vecs[13] = mkVec(32'h0000_3000, 2'd2, 1'b0, 32'h0BAD_F00D, 0, 16, 0, 32'hDEAD_BEEF, 1'b1, 18);
`else
    vecs[13] = mkVec(32'h0000_3000, 2'd2, 1'b0, 32'h0BAD_F00D, 0, 16, 0, 32'h0BAD_F00D, 1'b0, 19);
`endif

    #3;
    checkResetValues("reset");
    @(posedge clk); @(posedge clk); #1;
    nrst = 1'b1;
    @(posedge clk); #1;
    checkResetValues("after_reset");

    for (int i = 0; i < 14; i++) begin
      applyStimulus($sformatf("vec%0d", i), vecs[i]);
    end

    for (int i = 0; i < 40; i++) begin
      rv.addr = $urandom; rv.size = 2'($urandom_range(0, 3)); rv.uns = 1'($urandom);
      rv.rdata = $urandom;
      rv.gnt_dly = $urandom_range(0, 3); rv.rv_dly = $urandom_range(0, 3);
      rv.rdy_dly = $urandom_range(0, 3);
      refModel(rv.addr, rv.size, rv.uns, rv.rdata, md, me);
      rv.exp_data = md; rv.exp_err = me;
      rv.exp_lat = me ? 1 : 3 + rv.gnt_dly + rv.rv_dly;
      applyStimulus($sformatf("rand%0d", i), rv);
    end

    // Reset while waiting for read data, then a stray rvalid afterwards.
    ld_valid = 1'b1; ld_addr = 32'h1000_0008; ld_size = 2'd2; ld_unsigned = 1'b0;
    @(posedge clk); #1;
    ld_valid = 1'b0;
    checkOutput("wait_seq mem_req", {31'h0, mem_req}, 32'h1);
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    @(posedge clk); #2;
    nrst = 1'b0;
    #1;
    checkResetValues("reset_in_wait");
    @(posedge clk); #1;
    nrst = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h5555_5555;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    checkResetValues("late_rvalid");
    @(posedge clk); #1;
    checkResetValues("late_rvalid2");

    // Reset while requesting: mem_req must drop before the next edge.
    ld_valid = 1'b1; ld_addr = 32'h2000_0004; ld_size = 2'd2; ld_unsigned = 1'b0;
    @(posedge clk); #1;
    ld_valid = 1'b0;
    checkOutput("req_seq mem_addr", mem_addr, 32'h2000_0004);
    #2;
    nrst = 1'b0;
    #1;
    checkOutput("req_seq async_drop", {31'h0, mem_req}, 32'h0);
    checkOutput("req_seq addr_clear", mem_addr, 32'h0);
    @(posedge clk); #1;
    nrst = 1'b1;
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    checkResetValues("late_gnt");

    applyStimulus("post_reset", mkVec(32'h3000_0002, 2'd1, 1'b0, 32'h7FFF_0000, 0, 0, 0,
                                      32'h0000_7FFF, 1'b0, 3));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_extract_unit.md
Name: load_extract_unit

Overview:
- Read-side counterpart of the store-side byte-insert logic (wordmod).
- Accepts a load request (byte address, size, signedness) and issues a word-aligned read to data memory over a req/gnt/rvalid handshake.
- Selects the addressed byte or halfword lane from the returned word, sign- or zero-extends it, and returns the 32-bit result to the datapath over a valid/ready handshake.
- Sits between the MEM-stage load path and the data memory port.

Parameters:
- ADDR_W, 32, byte-address width; mem_addr has the same width.
- TIMEOUT_CYCLES, 16, WAIT-state watchdog limit; used only with LOAD_TIMEOUT_EN.

Ports:
- clk  in  1  rising-edge clock
- nrst  in  1  asynchronous active-low reset
- ld_valid  in  1  load request valid
- ld_ready  out  1  unit can accept a request; high only in IDLE
- ld_addr  in  ADDR_W  byte address of the load
- ld_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved
- ld_unsigned  in  1  1 = zero-extend (lbu/lhu); 0 = sign-extend
- mem_req  out  1  memory read request
- mem_addr  out  ADDR_W  word-aligned address {ld_addr[ADDR_W-1:2],2'b00}
- mem_gnt  in  1  memory accepted the request
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read word
- res_valid  out  1  result valid
- res_data  out  32  extended load result
- res_err  out  1  result is an error (misaligned, reserved size, or timeout)
- res_ready  in  1  consumer accepts the result

Behaviour:
- Clock and reset: one clock domain (clk). nrst is asynchronous and active-low.
- State machine: IDLE, REQ, WAIT, RESP. Reset state is IDLE.
- Reset values: mem_req=0, mem_addr=0, res_valid=0, res_data=0, res_err=0, ld_ready=1. ld_ready is decoded from state.
- Reset mid-operation: state returns to IDLE immediately and mem_req drops asynchronously. A late mem_rvalid or mem_gnt seen in IDLE is ignored.
- IDLE: on ld_valid, register offset=ld_addr[1:0], ld_size, ld_unsigned and mem_addr.
  - Error case: ld_size=11, halfword with offset[0]=1, or word with offset≠0 -> go to RESP with res_err=1 and res_data=0. No memory access is made.
  - Otherwise -> go to REQ.
- REQ: mem_req=1 and mem_addr held stable until mem_gnt. Go to WAIT on the mem_gnt cycle. mem_rvalid in REQ is ignored.
- WAIT: mem_req=0. On mem_rvalid, register the extracted result into res_data, set res_err=0, and go to RESP.
- RESP: res_valid=1; res_data and res_err held stable. On res_ready, go to IDLE; res_valid deasserts the next cycle.
- Minimum latency (gnt same cycle as req, rvalid the cycle after gnt):
  - request accepted at cycle 0; mem_req high at cycle 1;
  - rvalid at cycle 2; res_valid high at cycle 3.
- Back-to-back: a new request is accepted no earlier than the cycle after the RESP handshake.
- Lane selection (little-endian; offset 0 = bits [7:0], matching wordmod byte placement):
  - byte: mem_rdata[8*offset+7 : 8*offset]
  - halfword: offset 0 -> [15:0]; offset 2 -> [31:16]
  - word: mem_rdata unchanged; ld_unsigned is ignored.
- Extension: replicate the lane MSB into the upper bits when ld_unsigned=0, zero-fill when ld_unsigned=1.

Optional Feature:
- Macro: LOAD_TIMEOUT_EN.
- When defined:
  - A counter resets on entry to WAIT and increments each WAIT cycle without mem_rvalid.
  - On reaching TIMEOUT_CYCLES, go to RESP with res_err=1 and res_data=32'hDEAD_BEEF.
  - mem_rvalid arriving in the same cycle as the timeout wins (normal result).
- When undefined: no counter is instantiated, and WAIT lasts until mem_rvalid with no limit.

Test Plan:
- Signed byte load: ld_addr=0x81234561, size=00, unsigned=0, rdata=0xAAAA80AA -> mem_addr=0x81234560, res_data=0xFFFFFF80, res_err=0, res_valid high 3 cycles after acceptance (gnt immediate, rvalid next cycle).
- All byte offsets: ld_addr=0x81234560..0x81234563, unsigned=1, rdata=0x44332211 -> res_data=0x11, 0x22, 0x33, 0x44 respectively.
- Halfword loads:
  - ld_addr=0x81234562, size=01, unsigned=0, rdata=0x8001AAAA -> res_data=0xFFFF8001.
  - Same request with unsigned=1 -> res_data=0x00008001.
- Misaligned requests:
  - ld_addr=0x81234563, size=01 -> res_err=1, res_data=0, mem_req never asserts.
  - size=10 with offset 1 -> same response.
  - size=11 -> same response.
- Handshake stalls: mem_gnt held low 4 cycles (mem_req and mem_addr stable throughout); res_ready held low 3 cycles (res_valid and res_data stable); word load rdata=0xCAFEF00D -> res_data=0xCAFEF00D.
- Reset in WAIT: assert nrst=0 mid-WAIT, then drive mem_rvalid after release -> outputs at reset values, state IDLE, ld_ready=1, rvalid ignored.
- With LOAD_TIMEOUT_EN: no mem_rvalid for 16 WAIT cycles -> res_err=1, res_data=0xDEADBEEF.
